// File: rtl/kmul_pkg.sv
// ---------------------------------------------------------------------------
// kmul_pkg -- shared definitions for the kmul_pipe Karatsuba multiplier.
//
// Contents:
//   KMUL_LAT     pipeline depth from acceptance to out_valid (cycles)
//   KMUL_ACC_ON  1 when the accumulator option is compiled in
//   kmul_pw()    result width: 2W, or 2W+G with the accumulator option
//   kmul_ctl_t   control part of every stage payload (valid, acc flag);
//                each stage wraps it with its own W-dependent data fields
//
// Configuration macro: KMUL_ACC_EN (accumulator option).
// ---------------------------------------------------------------------------
package kmul_pkg;

    localparam int unsigned KMUL_LAT = 4;

`ifdef KMUL_ACC_EN
    localparam bit KMUL_ACC_ON = 1'b1;
`else
    localparam bit KMUL_ACC_ON = 1'b0;
`endif

    function automatic int unsigned kmul_pw(input int unsigned w,
                                            input int unsigned g,
                                            input bit          acc_en);
        return acc_en ? (2 * w + g) : (2 * w);
    endfunction

    typedef struct packed {
        logic valid;
        logic acc;
    } kmul_ctl_t;

endpackage

// File: rtl/kmul_half_mult.sv
// ---------------------------------------------------------------------------
// kmul_half_mult -- registered unsigned N x N multiplier (one Karatsuba leg).
//
// Ports:
//   clock, reset  clock / synchronous active-high reset (clears the product)
//   en            load enable; the product register holds while low
//   a, b          N-bit unsigned operands
//   p             2N-bit registered product
// ---------------------------------------------------------------------------
module kmul_half_mult #(
    parameter int unsigned N = 65
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           en,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] b_ext;

    assign a_ext = {{N{1'b0}}, a};
    assign b_ext = {{N{1'b0}}, b};

    always_ff @(posedge clock) begin
        if (reset) begin
            p <= '0;
        end else if (en) begin
            p <= a_ext * b_ext;
        end
    end

endmodule

// File: rtl/kmul_pipe.sv
// ---------------------------------------------------------------------------
// kmul_pipe -- 4-stage Karatsuba multiplier P = X * Y with a stored
// coefficient Y and valid/ready flow control.
//
// Ports:
//   clock, reset  clock / synchronous active-high reset
//   coef_we       coefficient write strobe; coef_in becomes Y next cycle
//   coef_in       W-bit new coefficient
//   in_valid      operand valid; accepted when in_valid && in_ready
//   in_ready      = !out_valid || out_ready
//   X             W-bit operand
//   in_acc        accumulate request (only with KMUL_ACC_EN)
//   P             PW-bit result (2W, or 2W+ACC_G with KMUL_ACC_EN)
//   out_valid     result valid; P and out_valid hold while !out_ready
//   out_ready     downstream accepts P
//
// Stages: S1 operand/coef snapshot and half sums, S2 three (H+1)-bit
// products, S3 middle term, S4 recombination into P.
// Configuration macro: KMUL_ACC_EN (accumulator, in_acc port, wider P).
// ---------------------------------------------------------------------------
module kmul_pipe
    import kmul_pkg::*;
#(
    parameter int unsigned  W         = 128,
    parameter int unsigned  ACC_G     = 8,
    parameter logic [W-1:0] COEF_INIT = '0,
    localparam int unsigned PW        = kmul_pw(W, ACC_G, KMUL_ACC_ON)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          coef_we,
    input  logic [W-1:0]  coef_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  X,
`ifdef KMUL_ACC_EN
    input  logic          in_acc,
`endif
    output logic [PW-1:0] P,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int unsigned H   = W / 2;
    localparam int unsigned M   = H + 1;      // half operand plus carry
    localparam int unsigned MW  = 2 * M;      // leg product width
    localparam int unsigned PRW = 2 * W;      // plain product width

    typedef struct packed {
        kmul_ctl_t      ctl;
        logic [H-1:0]   x1;
        logic [H-1:0]   x0;
        logic [H-1:0]   y1;
        logic [H-1:0]   y0;
        logic [M-1:0]   xs;
        logic [M-1:0]   ys;
    } s1_t;

    typedef struct packed {
        kmul_ctl_t      ctl;
        logic [MW-1:0]  p0;
        logic [MW-1:0]  p1;
        logic [MW-1:0]  mid;
    } s3_t;

    function automatic logic [M-1:0] half_sum(input logic [W-1:0] v);
        return M'(v[W-1:H]) + M'(v[H-1:0]);
    endfunction

    logic [W-1:0]        coef_q;
    logic [M-1:0]        coef_sum_q;
    s1_t                 s1;
    kmul_ctl_t           s2_ctl;
    s3_t                 s3;
    logic [MW-1:0]       p0_w;
    logic [MW-1:0]       p1_w;
    logic [MW-1:0]       pm_w;
    logic [KMUL_LAT-1:0] stage_v;
    logic                adv1;
    logic                adv2;
    logic                adv3;
    logic                adv_out;
    logic                acc_req;
    logic [PRW-1:0]      prod;
    logic [PW-1:0]       result;

    // Each stage loads when it is empty or its successor is loading, so
    // bubbles collapse behind a stalled output register.
    assign stage_v  = {out_valid, s3.ctl.valid, s2_ctl.valid, s1.ctl.valid};
    assign adv_out  = !stage_v[3] || out_ready;
    assign adv3     = !stage_v[2] || adv_out;
    assign adv2     = !stage_v[1] || adv3;
    assign adv1     = !stage_v[0] || adv2;
    assign in_ready = adv_out;

`ifdef KMUL_ACC_EN
    assign acc_req = in_acc;
`else
    assign acc_req = 1'b0;
`endif

    // The half sum of Y is stored alongside Y so S1 needs only one adder.
    always_ff @(posedge clock) begin
        if (reset) begin
            coef_q     <= COEF_INIT;
            coef_sum_q <= half_sum(COEF_INIT);
        end else if (coef_we) begin
            coef_q     <= coef_in;
            coef_sum_q <= half_sum(coef_in);
        end
    end

    // S1: snapshot operand and current coefficient.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= '0;
        end else if (adv1) begin
            s1.ctl.valid <= in_valid && in_ready;
            s1.ctl.acc   <= acc_req;
            s1.x1        <= X[W-1:H];
            s1.x0        <= X[H-1:0];
            s1.y1        <= coef_q[W-1:H];
            s1.y0        <= coef_q[H-1:0];
            s1.xs        <= half_sum(X);
            s1.ys        <= coef_sum_q;
        end
    end

    // S2: three registered legs.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_ctl <= '0;
        end else if (adv2) begin
            s2_ctl <= s1.ctl;
        end
    end

    kmul_half_mult #(.N(M)) u_p0 (
        .clock (clock),
        .reset (reset),
        .en    (adv2),
        .a     ({1'b0, s1.x0}),
        .b     ({1'b0, s1.y0}),
        .p     (p0_w)
    );

    kmul_half_mult #(.N(M)) u_p1 (
        .clock (clock),
        .reset (reset),
        .en    (adv2),
        .a     ({1'b0, s1.x1}),
        .b     ({1'b0, s1.y1}),
        .p     (p1_w)
    );

    kmul_half_mult #(.N(M)) u_pm (
        .clock (clock),
        .reset (reset),
        .en    (adv2),
        .a     (s1.xs),
        .b     (s1.ys),
        .p     (pm_w)
    );

    // S3: middle term; Pm >= P1 + P0, so the difference is exact in MW bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            s3 <= '0;
        end else if (adv3) begin
            s3.ctl <= s2_ctl;
            s3.p0  <= p0_w;
            s3.p1  <= p1_w;
            s3.mid <= pm_w - p1_w - p0_w;
        end
    end

    // S4: recombine at full product width.
    assign prod = (PRW'(s3.p1) << W) + (PRW'(s3.mid) << H) + PRW'(s3.p0);

`ifdef KMUL_ACC_EN
    logic [PW-1:0] acc_q;

    assign result = s3.ctl.acc ? (acc_q + PW'(prod)) : PW'(prod);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            P         <= '0;
            acc_q     <= '0;
        end else if (adv_out) begin
            out_valid <= s3.ctl.valid;
            if (s3.ctl.valid) begin
                P     <= result;
                acc_q <= result;
            end
        end
    end
`else
    logic unused_acc_flag;

    assign unused_acc_flag = s3.ctl.acc;
    assign result          = prod;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            P         <= '0;
        end else if (adv_out) begin
            out_valid <= s3.ctl.valid;
            if (s3.ctl.valid) begin
                P <= result;
            end
        end
    end
`endif

endmodule
